// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared rv32i types and constants for the data-memory path.
//   DMEM_BASE         : default byte address of data RAM word 0
//   mem_size_e        : load/store access size as encoded on req_size
//   dmem_state_e      : dmem_responder FSM states
//   access_misaligned : flags illegal sizes and misaligned half/word accesses
package rv32i_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    SIZE_B       = 2'd0,
    SIZE_H       = 2'd1,
    SIZE_W       = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } dmem_state_e;

  // True when the access cannot be performed for size/alignment reasons.
  function automatic logic access_misaligned(input logic [1:0] addr_lo, input mem_size_e size);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: synchronous single-port word SRAM with per-byte write enables.
//   clk   : clock
//   en    : access enable (read or write this cycle)
//   we    : 1 = write, 0 = read
//   be    : byte enables for writes, bit i covers wdata[8*i +: 8]
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; held otherwise
// The array has no reset; contents are undefined until written.
module sram_1rw_be #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: services rv32i data-port loads/stores over a valid/ready
// request/response handshake, backed by an internal word SRAM.
//   clk, reset_n     : clock, asynchronous active-low reset
//   req_valid/ready  : request handshake; ready only while idle
//   req_addr         : byte address
//   req_we           : 1 = store, 0 = load
//   req_size         : 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned     : zero-extend byte/half loads
//   req_wdata        : right-aligned store data
//   rsp_valid/ready  : response handshake
//   rsp_rdata        : extended load data, 0 for stores and faults
//   rsp_err          : access fault (misaligned, out of range, illegal size)
// One request outstanding: store/fault responses appear one cycle after
// accept, load responses two cycles after accept.
module dmem_responder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DMEM_BASE,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_SPAN = 33'(DEPTH_WORDS) << 2;

  dmem_state_e r_state;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [1:0]  r_byte_off;
  mem_size_e   r_size;
  logic        r_unsigned;

  logic [31:0]   w_off;
  logic          w_in_range;
  mem_size_e     w_size;
  logic          w_err;
  logic          w_accept;
  logic          w_sram_en;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_wdata;
  logic [31:0]   w_sram_rdata;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load_data;

  // Wraparound subtraction makes addresses below the base land far out of range.
  assign w_off      = req_addr - ADDR_BASE;
  assign w_in_range = {1'b0, w_off} < BYTE_SPAN;
  assign w_size     = mem_size_e'(req_size);
  assign w_err      = !w_in_range || access_misaligned(req_addr[1:0], w_size);
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_sram_en  = w_accept && !w_err;
  assign w_idx      = w_off[AW+1:2];

  // Store lane steering: replicate the narrow value across all lanes and let
  // the byte enables pick the addressed lanes.
  always_comb begin
    w_be         = 4'h0;
    w_lane_wdata = req_wdata;
    case (w_size)
      SIZE_B: begin
        w_be         = 4'b0001 << req_addr[1:0];
        w_lane_wdata = {4{req_wdata[7:0]}};
      end
      SIZE_H: begin
        w_be         = 4'b0011 << req_addr[1:0];
        w_lane_wdata = {2{req_wdata[15:0]}};
      end
      SIZE_W: begin
        w_be = 4'hF;
      end
      default: ;
    endcase
  end

  sram_1rw_be #(
    .DEPTH (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (w_sram_en),
    .we    (req_we),
    .be    (w_be),
    .addr  (w_idx),
    .wdata (w_lane_wdata),
    .rdata (w_sram_rdata)
  );

  // Load lane select and extension, using attributes captured at accept.
  assign w_shifted = w_sram_rdata >> {r_byte_off, 3'b000};

  always_comb begin
    w_load_data = w_sram_rdata;
    case (r_size)
      SIZE_B: w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H: w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_sram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_byte_off  <= 2'b00;
      r_size      <= SIZE_B;
      r_unsigned  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_byte_off  <= req_addr[1:0];
            r_size      <= w_size;
            r_unsigned  <= req_unsigned;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= w_err;
            if (w_err || req_we) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized load/store traffic checked
// against a byte-addressed reference memory model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned SPAN  = DEPTH * 4;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: byte offset from BASE -> byte value.
  logic [7:0] mdl_mem [int unsigned];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one access: fault rules, then byte-level memory.
  task automatic mdl_access(input logic [31:0] a, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
    logic [31:0] off;
    int nbytes;
    off    = a - BASE;
    nbytes = 1 << sz;
    rd     = 32'h0;
    err    = (sz == 2'd3) || (off >= SPAN) || ((int'(a[1:0]) % nbytes) != 0);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) mdl_mem[off + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nbytes; i++) rd = rd | (32'(mdl_mem[off + i]) << (8 * i));
        if (!uns && nbytes < 4 && rd[8*nbytes-1]) rd = rd | (32'hFFFF_FFFF << (8 * nbytes));
      end
    end
  endtask

  // Junk on the request bus while the responder is busy; it must be ignored.
  task automatic scramble_req();
    req_valid    = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_we       = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_wdata    = $urandom;
  endtask

  // Called at a negedge with the responder idle; returns at a negedge.
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input int stall,
                         output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat;
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_addr     = a;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    rsp_ready    = 1'b0;
    @(posedge clk);
    mdl_access(a, we, sz, uns, wd, exp_err, exp_rd);
    @(negedge clk);
    scramble_req();
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      check_eq("busy_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      scramble_req();
      lat++;
    end
    check_eq("rsp_latency", 32'(lat), (exp_err || we) ? 32'd1 : 32'd2);
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("resp_req_ready", 32'(req_ready), 32'd0);
    got_rd  = rsp_rdata;
    got_err = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      scramble_req();
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, exp_rd);
      check_eq("hold_err", 32'(rsp_err), 32'(exp_err));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("post_hs_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic        x_err;
    logic [31:0] x_rd;

    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Known contents for every word the random phase may load from.
    for (int w = 0; w < 16; w++) run_txn(BASE + 32'(4 * w), 1'b1, 2'd2, 1'b0, $urandom, 0, rd, er);
    run_txn(BASE + SPAN - 4, 1'b1, 2'd2, 1'b0, $urandom, 0, rd, er);

    run_txn(32'h8000_0010, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, rd, er);
    check_eq("sw_rdata", rd, 32'h0);
    check_eq("sw_err", 32'(er), 32'd0);
    run_txn(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_eq("lw_deadbeef", rd, 32'hDEAD_BEEF);
    run_txn(32'h8000_0011, 1'b0, 2'd0, 1'b0, 32'h0, 0, rd, er);
    check_eq("lb_signed", rd, 32'hFFFF_FFBE);
    run_txn(32'h8000_0011, 1'b0, 2'd0, 1'b1, 32'h0, 0, rd, er);
    check_eq("lbu", rd, 32'h0000_00BE);
    run_txn(32'h8000_0012, 1'b0, 2'd1, 1'b0, 32'h0, 0, rd, er);
    check_eq("lh_signed", rd, 32'hFFFF_DEAD);
    run_txn(32'h8000_0013, 1'b1, 2'd0, 1'b0, 32'h1234_565A, 0, rd, er);
    run_txn(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_eq("lw_after_sb", rd, 32'h5AAD_BEEF);

    run_txn(32'h8000_0001, 1'b0, 2'd1, 1'b0, 32'h0, 0, rd, er);
    check_eq("lh_misaligned_err", 32'(er), 32'd1);
    check_eq("lh_misaligned_rdata", rd, 32'h0);
    run_txn(32'h8000_0000, 1'b1, 2'd2, 1'b0, 32'h1357_9BDF, 0, rd, er);
    run_txn(32'h7FFF_FFFC, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF, 0, rd, er);
    check_eq("sw_below_base_err", 32'(er), 32'd1);
    run_txn(32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_eq("lw_base_unchanged", rd, 32'h1357_9BDF);
    run_txn(BASE + SPAN - 4, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    run_txn(32'h8000_0004, 1'b0, 2'd3, 1'b0, 32'h0, 0, rd, er);
    check_eq("size3_err", 32'(er), 32'd1);
    run_txn(BASE + SPAN, 1'b0, 2'd0, 1'b0, 32'h0, 0, rd, er);
    check_eq("past_end_err", 32'(er), 32'd1);
    run_txn(BASE + SPAN - 1, 1'b0, 2'd0, 1'b1, 32'h0, 0, rd, er);
    check_eq("last_byte_err", 32'(er), 32'd0);

    // Backpressure on a load response.
    run_txn(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 5, rd, er);
    check_eq("stall_lw", rd, 32'h5AAD_BEEF);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + SPAN + 32'($urandom_range(0, 7));
        1:       a = BASE - 32'($urandom_range(1, 8));
        2:       a = BASE + SPAN - 32'($urandom_range(1, 4));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      run_txn(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, int'($urandom_range(0, 3)), rd, er);
    end

    // Reset while a load is in RD_WAIT.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0010;
    req_we    = 1'b0;
    req_size  = 2'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_reset_outputs("rst_rd_wait");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rd_wait_rel");
    run_txn(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er);

    // Reset while a store response is pending; the store must persist.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0020;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_wdata = 32'hA5C3_0F96;
    @(posedge clk);
    mdl_access(32'h8000_0020, 1'b1, 2'd2, 1'b0, 32'hA5C3_0F96, x_err, x_rd);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_txn(32'h8000_0020, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_eq("store_survives_reset", rd, 32'hA5C3_0F96);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
